counter_seq_ctl: RTL and testbench
==================================

COUNTER_SEQ_CTL -- requirements
Module: counter_seq_ctl

Interface
REQ-001 Parameter WIDTH, default 16: counter and reload width in bits.
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 RSTL  input  1  reset, asynchronous, active-low.
REQ-004 WR_RELOAD  input  1  write strobe; captures DIN into the reload register.
REQ-005 DIN  input  WIDTH  reload value.
REQ-006 START  input  1  request to load the counter and begin counting.
REQ-007 STOP  input  1  request to halt counting; COUNT holds its value.
REQ-008 MODE  input  1  0 = one-shot, 1 = periodic; sampled every cycle.
REQ-009 TICK  input  1  count-enable qualifier, one decrement per high cycle in RUN.
REQ-010 CLR_IRQ  input  1  clears IRQ.
REQ-011 COUNT  output  WIDTH  current counter value.
REQ-012 RUNNING  output  1  high while in state RUN.
REQ-013 TC  output  1  one-cycle terminal-count pulse.
REQ-014 IRQ  output  1  sticky terminal-count flag.

Function
REQ-015 The block SHALL implement states IDLE, LOAD, RUN; encoding is binary.
REQ-016 IDLE: START=1 and STOP=0 -> LOAD next cycle; otherwise remain IDLE with COUNT held.
REQ-017 LOAD: COUNT <= reload register; next state RUN unconditionally, except STOP=1 -> IDLE with the load still performed.
REQ-018 RUN: TICK=1 and COUNT!=0 -> COUNT <= COUNT-1; TICK=0 -> COUNT held.
REQ-019 RUN, TICK=1 and COUNT==0: TC=1 that cycle (combinational from state, TICK and COUNT), IRQ set at the next edge.
REQ-020 At expiry with MODE=1: COUNT <= reload register, remain RUN; period = reload+1 TICKs.
REQ-021 At expiry with MODE=0: COUNT stays 0, next state IDLE.
REQ-022 Reload value 0 SHALL produce TC on every TICK in periodic mode; no special-case wrap to 2^WIDTH.
REQ-023 STOP=1 in RUN -> IDLE next cycle; STOP has priority over TICK, so no decrement and no TC that cycle.
REQ-024 START while in LOAD or RUN SHALL be ignored; restart requires STOP then START.
REQ-025 START and STOP asserted together in IDLE: STOP wins, remain IDLE.
REQ-026 WR_RELOAD in any state updates the reload register only; a new value takes effect at the next LOAD or periodic reload, never mid-count.
REQ-027 WR_RELOAD coincident with a periodic reload: the counter loads the old register value; the new value applies at the following reload.
REQ-028 CLR_IRQ and IRQ set in the same cycle: set wins, IRQ remains 1.
REQ-029 Arithmetic is unsigned modulo 2^WIDTH; decrement below 0 SHALL never occur.

Reset
REQ-030 RSTL=0 asynchronously forces state IDLE, COUNT=0, reload register=0, IRQ=0; hence RUNNING=0 and TC=0.
REQ-031 Reset asserted mid-count SHALL abandon the count with no TC or IRQ; after release the block waits in IDLE for START.
REQ-032 Reset release SHALL be synchronised by the integrating level; the block adds no synchroniser.

Structure
REQ-033 State enumeration type and the MODE_ONESHOT/MODE_PERIODIC constants SHALL live in the shared timer package.
REQ-034 The counter register SHALL be one sub-module, count_reg, built as a chain of WIDTH loadable counter cells (load, borrow chain, async reset); counter_seq_ctl drives its load, enable and load data.
REQ-035 The zero-detect SHALL be derived from the chain's final borrow output, not from a separate WIDTH-wide compare.

Verification
REQ-036 Reset, WR_RELOAD DIN=3, MODE=0, START, TICK held 1 -> COUNT 3,2,1,0; TC on the 4th RUN tick; IRQ=1 next cycle; state IDLE, COUNT=0.
REQ-037 Reload 2, MODE=1, TICK=1 for 9 RUN cycles -> TC on RUN cycles 3, 6 and 9; RUNNING stays 1.
REQ-038 Reload 5, run 2 TICKs, STOP -> COUNT=3 held, RUNNING=0, no TC; START -> COUNT=5.
REQ-039 Periodic reload 1; WR_RELOAD DIN=4 in the same cycle as an expiry -> next period counts from 1; the period after counts from 4.
REQ-040 IRQ=1, CLR_IRQ in the same cycle as a new TC -> IRQ stays 1; CLR_IRQ alone next cycle -> IRQ=0.
REQ-041 RSTL pulsed low mid-count at COUNT=7 -> COUNT=0, IRQ=0, IDLE immediately; TICK after release -> no change.

Source files
------------

// File: rtl/counter_seq_ctl_pkg.sv
// Shared timer definitions: sequencer state encoding and mode constants.
package counter_seq_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_seq_ctl_if.sv
// Control/status bundle of the timer; master drives commands, slave is the timer.
interface counter_seq_ctl_if #(
    parameter int WIDTH = 16
);
    logic             i_wr_reload;
    logic [WIDTH-1:0] i_din;
    logic             i_start;
    logic             i_stop;
    logic             i_mode;
    logic             i_tick;
    logic             i_clr_irq;
    logic [WIDTH-1:0] o_count;
    logic             o_running;
    logic             o_tc;
    logic             o_irq;

    modport master (
        output i_wr_reload, i_din, i_start, i_stop, i_mode, i_tick, i_clr_irq,
        input  o_count, o_running, o_tc, o_irq
    );

    modport slave (
        input  i_wr_reload, i_din, i_start, i_stop, i_mode, i_tick, i_clr_irq,
        output o_count, o_running, o_tc, o_irq
    );
endinterface

// File: rtl/counter_seq_ctl_count_reg.sv
// Loadable down-counter built from a ripple chain of single-bit cells.
// Zero is the borrow falling out of the top cell: it is high only when every bit is 0.
module count_cell (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    input  logic i_ld_bit,
    input  logic i_borrow,
    output logic o_q,
    output logic o_borrow
);
    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= 1'b0;
        end else if (i_load) begin
            r_q <= i_ld_bit;
        end else if (i_en) begin
            r_q <= r_q ^ i_borrow;
        end
    end

    assign o_q      = r_q;
    assign o_borrow = i_borrow & ~r_q;
endmodule

module count_reg #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_ld_dat,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);
    // Each stage owns its borrow wire so the chain is not one self-referencing vector.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        logic w_bin;
        logic w_bout;
        logic w_q;

        if (gi == 0) begin : g_lsb
            assign w_bin = 1'b1;
        end else begin : g_upper
            assign w_bin = g_cell[gi-1].w_bout;
        end

        count_cell u_cell (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_load   (i_load),
            .i_en     (i_en),
            .i_ld_bit (i_ld_dat[gi]),
            .i_borrow (w_bin),
            .o_q      (w_q),
            .o_borrow (w_bout)
        );

        assign o_count[gi] = w_q;
    end

    assign o_zero = g_cell[WIDTH-1].w_bout;
endmodule

// File: rtl/counter_seq_ctl.sv
// Timer sequencer IDLE -> LOAD -> RUN with one-shot/periodic expiry, sticky IRQ.
// TC is combinational in the expiry cycle; STOP outranks TICK and START.
module counter_seq_ctl
    import counter_seq_ctl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    counter_seq_ctl_if.slave    bus
);
    state_t           r_state;
    logic [WIDTH-1:0] r_reload;
    logic             r_running;
    logic             r_irq;

    logic             w_zero;
    logic             w_step;
    logic             w_expire;
    logic             w_load;
    logic             w_en;
    logic [WIDTH-1:0] w_count;

    assign w_step   = (r_state == ST_RUN) && !bus.i_stop && bus.i_tick;
    assign w_expire = w_step && w_zero;
    assign w_en     = w_step && !w_zero;
    // A reload latched in the same cycle is not seen here; it waits for the next load.
    assign w_load   = (r_state == ST_LOAD) || (w_expire && (bus.i_mode == MODE_PERIODIC));

    count_reg #(.WIDTH(WIDTH)) u_count_reg (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_load),
        .i_en     (w_en),
        .i_ld_dat (r_reload),
        .o_count  (w_count),
        .o_zero   (w_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_reload  <= '0;
            r_running <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (bus.i_wr_reload) begin
                r_reload <= bus.i_din;
            end

            if (w_expire) begin
                r_irq <= 1'b1;
            end else if (bus.i_clr_irq) begin
                r_irq <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start && !bus.i_stop) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (bus.i_stop) begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end else begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.i_stop || (w_expire && (bus.i_mode == MODE_ONESHOT))) begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_count   = w_count;
    assign bus.o_running = r_running;
    assign bus.o_tc      = w_expire;
    assign bus.o_irq     = r_irq;
endmodule

// File: tb/tb_counter_seq_ctl.sv
// Directed bench for counter_seq_ctl: behavioural timer model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_counter_seq_ctl;
    localparam int WIDTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    counter_seq_ctl_if #(.WIDTH(WIDTH)) ifc ();

    counter_seq_ctl #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 = waiting, 1 = loading, 2 = counting.
    int          m_phase  = 0;
    int unsigned m_count  = 0;
    int unsigned m_reload = 0;
    bit          m_irq    = 1'b0;

    function automatic bit model_tc();
        return (m_phase == 2) && ifc.i_tick && !ifc.i_stop && (m_count == 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int unsigned new_reload;
        bit          expired;
        if (!rst_n) begin
            m_phase  = 0;
            m_count  = 0;
            m_reload = 0;
            m_irq    = 1'b0;
        end else begin
            expired    = model_tc();
            new_reload = ifc.i_wr_reload ? int'(ifc.i_din) : m_reload;
            if (m_phase == 0) begin
                if (ifc.i_start && !ifc.i_stop) m_phase = 1;
            end else if (m_phase == 1) begin
                m_count = m_reload;
                m_phase = ifc.i_stop ? 0 : 2;
            end else begin
                if (ifc.i_stop) begin
                    m_phase = 0;
                end else if (ifc.i_tick) begin
                    if (m_count > 0) m_count = m_count - 1;
                    else if (ifc.i_mode) m_count = m_reload;
                    else m_phase = 0;
                end
            end
            if (expired) m_irq = 1'b1;
            else if (ifc.i_clr_irq) m_irq = 1'b0;
            m_reload = new_reload;
        end
    end

    always @(negedge clk) begin
        chk("cmp_count",   32'(ifc.o_count),   32'(m_count));
        chk("cmp_running", 32'(ifc.o_running), 32'(m_phase == 2));
        chk("cmp_tc",      32'(ifc.o_tc),      32'(model_tc()));
        chk("cmp_irq",     32'(ifc.o_irq),     32'(m_irq));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.i_wr_reload = 1'b0;
        ifc.i_din       = '0;
        ifc.i_start     = 1'b0;
        ifc.i_stop      = 1'b0;
        ifc.i_tick      = 1'b0;
        ifc.i_clr_irq   = 1'b0;
    endtask

    initial begin
        idle_inputs();
        ifc.i_mode = 1'b0;
        repeat (2) cyc();
        chk("rst_count",   32'(ifc.o_count),   32'd0);
        chk("rst_running", 32'(ifc.o_running), 32'd0);
        chk("rst_tc",      32'(ifc.o_tc),      32'd0);
        chk("rst_irq",     32'(ifc.o_irq),     32'd0);
        rst_n = 1'b1;
        cyc();

        // One-shot, reload 3.
        ifc.i_wr_reload = 1'b1; ifc.i_din = 16'd3; cyc();
        ifc.i_wr_reload = 1'b0; ifc.i_mode = 1'b0; ifc.i_start = 1'b1; cyc();
        ifc.i_start = 1'b0; ifc.i_tick = 1'b1; cyc();
        chk("os_load_count", 32'(ifc.o_count), 32'd3);
        chk("os_running",    32'(ifc.o_running), 32'd1);
        for (int v = 2; v >= 0; v--) begin
            cyc();
            chk("os_count", 32'(ifc.o_count), 32'(v));
        end
        chk("os_tc_4th", 32'(ifc.o_tc), 32'd1);
        cyc();
        chk("os_irq",     32'(ifc.o_irq),     32'd1);
        chk("os_idle",    32'(ifc.o_running), 32'd0);
        chk("os_count_0", 32'(ifc.o_count),   32'd0);
        ifc.i_tick = 1'b0; ifc.i_clr_irq = 1'b1; cyc();
        ifc.i_clr_irq = 1'b0;

        // Periodic, reload 2: TC on run cycles 3, 6, 9.
        ifc.i_wr_reload = 1'b1; ifc.i_din = 16'd2; ifc.i_mode = 1'b1; ifc.i_start = 1'b1; cyc();
        ifc.i_wr_reload = 1'b0; ifc.i_start = 1'b0; ifc.i_tick = 1'b1; cyc();
        for (int i = 1; i <= 9; i++) begin
            chk("per_tc",      32'(ifc.o_tc),      32'(i % 3 == 0));
            chk("per_running", 32'(ifc.o_running), 32'd1);
            cyc();
        end
        ifc.i_stop = 1'b1; ifc.i_clr_irq = 1'b1; cyc();
        ifc.i_stop = 1'b0; ifc.i_clr_irq = 1'b0; ifc.i_tick = 1'b0; cyc();

        // Reload 5, two ticks (START ignored meanwhile), STOP holds, START reloads.
        ifc.i_wr_reload = 1'b1; ifc.i_din = 16'd5; ifc.i_mode = 1'b0; ifc.i_start = 1'b1; cyc();
        ifc.i_wr_reload = 1'b0; ifc.i_tick = 1'b1; cyc();
        cyc();
        cyc();
        chk("stop_count_pre", 32'(ifc.o_count), 32'd3);
        ifc.i_start = 1'b0; ifc.i_stop = 1'b1;
        #1 chk("stop_no_tc", 32'(ifc.o_tc), 32'd0);
        cyc();
        ifc.i_stop = 1'b0; cyc();
        chk("stop_hold",    32'(ifc.o_count),   32'd3);
        chk("stop_running", 32'(ifc.o_running), 32'd0);
        ifc.i_tick = 1'b0; ifc.i_start = 1'b1; cyc();
        ifc.i_start = 1'b0; cyc();
        chk("restart_count", 32'(ifc.o_count), 32'd5);
        ifc.i_stop = 1'b1; cyc();
        ifc.i_stop = 1'b0;

        // Periodic reload 1, new reload written on the expiry cycle.
        ifc.i_wr_reload = 1'b1; ifc.i_din = 16'd1; ifc.i_mode = 1'b1; ifc.i_start = 1'b1; cyc();
        ifc.i_wr_reload = 1'b0; ifc.i_start = 1'b0; ifc.i_tick = 1'b1; cyc();
        chk("wr_first", 32'(ifc.o_count), 32'd1);
        cyc();
        chk("wr_exp_tc", 32'(ifc.o_tc), 32'd1);
        ifc.i_wr_reload = 1'b1; ifc.i_din = 16'd4; cyc();
        ifc.i_wr_reload = 1'b0;
        chk("wr_old_val", 32'(ifc.o_count), 32'd1);
        cyc();
        cyc();
        chk("wr_new_val", 32'(ifc.o_count), 32'd4);

        // IRQ set beats CLR_IRQ, then CLR_IRQ alone clears.
        repeat (4) cyc();
        ifc.i_clr_irq = 1'b1;
        #1 chk("irq_tc",  32'(ifc.o_tc),  32'd1);
        chk("irq_pre", 32'(ifc.o_irq), 32'd1);
        cyc();
        chk("irq_set_wins", 32'(ifc.o_irq), 32'd1);
        ifc.i_tick = 1'b0; cyc();
        chk("irq_cleared", 32'(ifc.o_irq), 32'd0);
        ifc.i_clr_irq = 1'b0; ifc.i_stop = 1'b1; cyc();
        ifc.i_stop = 1'b0;

        // Reset mid-count at 7.
        ifc.i_wr_reload = 1'b1; ifc.i_din = 16'd9; ifc.i_mode = 1'b0; ifc.i_start = 1'b1; cyc();
        ifc.i_wr_reload = 1'b0; ifc.i_start = 1'b0; ifc.i_tick = 1'b1; cyc();
        cyc();
        cyc();
        chk("mid_count_7", 32'(ifc.o_count), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count",   32'(ifc.o_count),   32'd0);
        chk("arst_irq",     32'(ifc.o_irq),     32'd0);
        chk("arst_running", 32'(ifc.o_running), 32'd0);
        chk("arst_tc",      32'(ifc.o_tc),      32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("post_rst_count",   32'(ifc.o_count),   32'd0);
        chk("post_rst_running", 32'(ifc.o_running), 32'd0);
        ifc.i_tick = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
